line_data_memory: RTL and testbench
===================================

# line_data_memory

Line-granular backing memory: the responder end of the cache-to-memory handshake. Accepts one whole-line read or write per request, holds it for a fixed latency, then returns the line (reads) or commits it (writes). Sits below the data cache and replaces the behavioural memory model with a synthesizable, cycle-exact responder.

## Interface
- BLOCK_SIZE, 16: line size in bytes; data ports are BLOCK_SIZE*8 bits.
- NUM_LINES, 1024: number of lines stored; power of two.
- DELAY, 50: cycles a request stays busy; must be ≥1.
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- is_input_valid  in  1  request present this cycle.
- addr  in  32  line index (byte address already shifted right by CLOG2(BLOCK_SIZE)); only low CLOG2(NUM_LINES) bits used.
- mem_read  in  1  request is a line read.
- mem_write  in  1  request is a line write.
- din  in  BLOCK_SIZE*8  write line.
- is_output_valid  out  1  dout holds read data; one-cycle pulse, reads only.
- dout  out  BLOCK_SIZE*8  read line.
- mem_ready  out  1  block will accept a request this cycle.

## Operation
- States: IDLE, BUSY, RESP, plus CLEAR when the macro below is compiled in.
- IDLE: mem_ready=1. Accept iff is_input_valid && (mem_read ^ mem_write); capture addr index, din, op; load counter with DELAY-1; go BUSY. Neither or both op bits set: ignored, stay IDLE.
- BUSY: mem_ready=0; counter decrements each cycle. At count 0: read → latch array[index] into dout register, go RESP; write → array[index] <= captured din, go IDLE.
- RESP: is_output_valid=1, dout valid; unconditionally IDLE next cycle (no back-pressure).
- Inputs are ignored outside IDLE; din/addr changes after acceptance have no effect.
- Writes never assert is_output_valid (initiator waits for mem_ready instead).
- Index out of range: wraps modulo NUM_LINES.
- Reset values: mem_ready=1 (0 if CLEAR entered), is_output_valid=0, dout=0, state IDLE, counter 0.
- Reset mid-operation: request aborted, pending write not committed, no response pulse.

## Timing
- Request accepted at edge ending cycle T.
- Read: mem_ready=0 in cycles T+1..T+DELAY+1; is_output_valid=1 in cycle T+DELAY+1; mem_ready=1 from T+DELAY+2.
- Write: array updated at edge ending T+DELAY; mem_ready=1 from T+DELAY+1; a read accepted then returns the new data.
- Back-to-back throughput: one read per DELAY+2 cycles, one write per DELAY+1 cycles.

## Configuration
- DMEM_CLEAR_ON_RESET_EN defined: after reset deasserts, CLEAR state zeroes one line per cycle, index 0..NUM_LINES-1; mem_ready=0 throughout; IDLE in cycle NUM_LINES after reset release. Reset during CLEAR restarts at 0.
- Undefined: array contents preserved across reset; IDLE and mem_ready=1 immediately after reset.

## Structure
- Shared package: state encodings, default BLOCK_SIZE/NUM_LINES/DELAY, line-width and index-width localparams (CLOG2-based).
- One sub-module, line_ram: single-port NUM_LINES × BLOCK_SIZE*8 array, synchronous write, registered read; control FSM and counter stay in the top.

## Test plan
- DELAY=4: read of index 3 preloaded 128'hA5.. accepted at T → is_output_valid only in T+5, dout=128'hA5.., mem_ready low T+1..T+5.
- Write 128'h1234 to index 7 then read index 7 → second request accepted at T+5, returns 128'h1234.
- is_input_valid with mem_read=mem_write=1, and requests issued during BUSY → no acceptance, no pulse, contents unchanged.
- addr=NUM_LINES+2 write then addr=2 read → same data returned (wrap).
- Reset asserted at T+2 of a write → no commit, is_output_valid=0, mem_ready=1 next cycle (macro off); old data readable.
- Macro on: reset release → mem_ready=0 for NUM_LINES cycles, every line then reads 0.

Source files
------------

// File: rtl/line_data_memory_pkg.sv
// Shared definitions for the line-granular backing memory: default geometry,
// derived widths and control-FSM state encodings.
package line_data_memory_pkg;

  localparam int DEF_BLOCK_SIZE = 16;
  localparam int DEF_NUM_LINES  = 1024;
  localparam int DEF_DELAY      = 50;
  localparam int DEF_LINE_W     = DEF_BLOCK_SIZE * 8;
  localparam int DEF_IDX_W      = $clog2(DEF_NUM_LINES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  function automatic int cnt_width(input int delay);
    return (delay > 1) ? $clog2(delay) : 1;
  endfunction

endpackage

// File: rtl/line_data_memory_line_ram.sv
// Single-port line array: synchronous write, registered read whose output
// register clears on reset.
module line_ram #(
  parameter int LINE_W    = 128,
  parameter int NUM_LINES = 1024,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [NUM_LINES];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/line_data_memory.sv
// Cycle-exact line memory responder with a fixed busy latency per request.
// Optional build macro DMEM_CLEAR_ON_RESET_EN zeroes the array after reset.
//   state | meaning
//   IDLE  | ready, waiting for a read or write request
//   BUSY  | request held, latency counter running down
//   RESP  | read line on dout, is_output_valid pulse
//   CLEAR | zeroing one line per cycle after reset (macro builds only)
module line_data_memory
  import line_data_memory_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int DELAY      = DEF_DELAY
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int LINE_W = BLOCK_SIZE * 8;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int CNT_W  = cnt_width(DELAY);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] din_q;
  logic              op_wr_q;

  logic              ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_addr;
  logic [LINE_W-1:0] ram_wdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:IDX_W];

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam logic [1:0] RESET_STATE = S_CLEAR;
  logic [IDX_W-1:0] clr_idx;
`else
  localparam logic [1:0] RESET_STATE = S_IDLE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RESET_STATE;
      cnt     <= '0;
      idx_q   <= '0;
      din_q   <= '0;
      op_wr_q <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      clr_idx <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (is_input_valid && (mem_read ^ mem_write)) begin
            idx_q   <= addr[IDX_W-1:0];
            din_q   <= din;
            op_wr_q <= mem_write;
            cnt     <= CNT_W'(DELAY - 1);
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == '0) state <= op_wr_q ? S_IDLE : S_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        S_RESP: state <= S_IDLE;
`ifdef DMEM_CLEAR_ON_RESET_EN
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IDX_W'(NUM_LINES - 1)) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array access is gated by reset so an aborted write never lands.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = idx_q;
    ram_wdata = din_q;
    if (!reset && state == S_BUSY && cnt == '0) begin
      ram_we = op_wr_q;
      ram_re = !op_wr_q;
    end
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (!reset && state == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_idx;
      ram_wdata = '0;
    end
`endif
  end

  line_ram #(
    .LINE_W    (LINE_W),
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_line_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (dout)
  );

  assign mem_ready       = (state == S_IDLE);
  assign is_output_valid = (state == S_RESP);

endmodule

// File: tb/tb_line_data_memory.sv
// Scoreboard bench for line_data_memory (DELAY=4, NUM_LINES=16); also covers
// the DMEM_CLEAR_ON_RESET_EN build when that macro is defined.
module tb_line_data_memory;

  localparam int BS = 16;
  localparam int NL = 16;
  localparam int DL = 4;
  localparam int LW = BS * 8;

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam logic RST_READY = 1'b0;
  localparam int   CLEAR_CYC = NL;
`else
  localparam logic RST_READY = 1'b1;
  localparam int   CLEAR_CYC = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          is_input_valid;
  logic [31:0]   addr;
  logic          mem_read;
  logic          mem_write;
  logic [LW-1:0] din;
  logic          is_output_valid;
  logic [LW-1:0] dout;
  logic          mem_ready;

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_q[$];

  always #5 clk = ~clk;

  line_data_memory #(.BLOCK_SIZE(BS), .NUM_LINES(NL), .DELAY(DL)) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .mem_ready       (mem_ready)
  );

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every read pulse is matched against the oldest expected line.
  always @(negedge clk) begin
    if (is_output_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got dout %h expected no pulse", dout);
      end else begin
        logic [LW-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL read_data: got %h expected %h", dout, e);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [LW-1:0] d);
    int n = 0;
    while (!mem_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ready) chk("ready_timeout", {127'd0, mem_ready}, 1);
    is_input_valid = 1'b1;
    mem_read = rd;
    mem_write = wr;
    addr = a;
    din = d;
    @(negedge clk);
    is_input_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    din = '0;
  endtask

  task automatic wr_line(input logic [31:0] a, input logic [LW-1:0] d);
    issue(1'b0, 1'b1, a, d);
  endtask

  task automatic rd_line(input logic [31:0] a, input logic [LW-1:0] e);
    exp_q.push_back(e);
    issue(1'b1, 1'b0, a, '0);
  endtask

  localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] PAT_C3 = {16{8'hC3}};
  localparam logic [LW-1:0] V1234  = 128'h1234;

  int n;
  logic [LW-1:0] old3;
  logic [31:0]   tbl_addr [3];
  logic [LW-1:0] tbl_data [3];

  initial begin
    reset = 1'b1;
    is_input_valid = 1'b0;
    addr = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    din = '0;
    tbl_addr[0] = 32'd0;  tbl_data[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tbl_addr[1] = 32'd5;  tbl_data[1] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl_addr[2] = 32'd15; tbl_data[2] = 128'h1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {127'd0, is_output_valid}, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ready", {127'd0, mem_ready}, {127'd0, RST_READY});
    reset = 1'b0;
    n = 0;
    while (!mem_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("clear_cycles", n, CLEAR_CYC);

`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < NL; i++) rd_line(i, '0);
`endif

    // Read latency and ready window; a write issued mid-BUSY must be ignored.
    wr_line(3, PAT_A5);
    rd_line(3, PAT_A5);
    for (int k = 0; k < DL + 1; k++) begin
      chk($sformatf("rd_ready_low_%0d", k), {127'd0, mem_ready}, 0);
      chk($sformatf("rd_valid_%0d", k), {127'd0, is_output_valid}, {127'd0, (k == DL)});
      if (k == 1) begin
        is_input_valid = 1'b1; mem_write = 1'b1; addr = 3; din = 128'hBAD;
      end else begin
        is_input_valid = 1'b0; mem_write = 1'b0; din = '0;
      end
      @(negedge clk);
    end
    chk("rd_ready_back", {127'd0, mem_ready}, 1);

    // Write-then-read: read accepted DELAY+1 cycles after the write.
    wr_line(7, V1234);
    n = 0;
    while (!mem_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready_gap", n, DL);
    rd_line(7, V1234);

    // Both op bits set: not accepted.
    n = 0;
    while (!mem_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    is_input_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; addr = 7; din = '1;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; din = '0;
    chk("both_ops_ignored", {127'd0, mem_ready}, 1);
    rd_line(7, V1234);
    rd_line(3, PAT_A5);

    // Index wrap.
    wr_line(NL + 2, PAT_C3);
    rd_line(2, PAT_C3);

    // Back-to-back table.
    for (int i = 0; i < 3; i++) wr_line(tbl_addr[i], tbl_data[i]);
    for (int i = 0; i < 3; i++) rd_line(tbl_addr[i], tbl_data[i]);

    // Reset in the middle of a write.
    wr_line(3, 128'hDEAD);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valid", {127'd0, is_output_valid}, 0);
    chk("abort_ready", {127'd0, mem_ready}, {127'd0, RST_READY});
`ifdef DMEM_CLEAR_ON_RESET_EN
    old3 = '0;
`else
    old3 = PAT_A5;
`endif
    rd_line(3, old3);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
